// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan driver: per-digit dead-time blank, PWM dimming,
// and frame-coherent snapshot of the digit patterns and brightness.
module seg_scan_mux #(
  parameter int unsigned DIGIT_TICKS      = 50000,
  parameter int unsigned BLANK_TICKS      = 500,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_seg_in_1,
  input  logic [7:0] i_seg_in_2,
  input  logic [7:0] i_seg_in_3,
  input  logic [7:0] i_seg_in_4,
  input  logic [2:0] i_bright,
  output logic [3:0] o_an,
  output logic [7:0] o_seg,
  output logic       o_frame_tick
);

  localparam int unsigned CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned LIT_W = CNT_W + 4;
  localparam logic [3:0]  AN_OFF = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_ON,
    S_OFF
  } state_t;

  state_t            r_state;
  state_t            w_nxt_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic [1:0]        r_dig;
  logic [1:0]        w_nxt_dig;
  logic [3:0][7:0]   r_snap;
  logic [2:0]        r_bright;
  logic [3:0]        r_an;
  logic [7:0]        r_seg;
  logic              r_frame_tick;

  logic              w_frame_start;
  logic [3:0]        w_nxt_an;
  logic [7:0]        w_nxt_seg;
  logic [3:0]        w_onehot;
  logic [LIT_W-1:0]  w_lit_prod;
  logic [LIT_W-1:0]  w_lit;
  logic [LIT_W-1:0]  w_on_end;

  // Lit length of the ON phase from the latched brightness, never below one cycle.
  always_comb begin
    w_lit_prod = LIT_W'(DIGIT_TICKS - BLANK_TICKS) * (LIT_W'(r_bright) + LIT_W'(1));
    w_lit      = LIT_W'(w_lit_prod >> 3);
    if (w_lit == '0) begin
      w_lit = LIT_W'(1);
    end
    w_on_end = LIT_W'(BLANK_TICKS) + w_lit;
  end

  // Next-state and output decode; outputs reflect the counter value of the next cycle.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_dig     = r_dig;
    w_frame_start = 1'b0;
    w_nxt_an      = AN_OFF;
    w_nxt_seg     = 8'hFF;
    w_onehot      = 4'b0000;

    if (!i_en) begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = '0;
      w_nxt_dig   = '0;
    end else begin
      if (r_state == S_IDLE) begin
        w_nxt_cnt = '0;
        w_nxt_dig = '0;
      end else if (r_cnt == CNT_W'(DIGIT_TICKS - 1)) begin
        w_nxt_cnt = '0;
        w_nxt_dig = r_dig + 2'd1;
      end else begin
        w_nxt_cnt = r_cnt + CNT_W'(1);
      end

      w_frame_start = (w_nxt_cnt == '0) && (w_nxt_dig == '0);

      if (LIT_W'(w_nxt_cnt) < LIT_W'(BLANK_TICKS)) begin
        w_nxt_state = S_BLANK;
      end else if (LIT_W'(w_nxt_cnt) < w_on_end) begin
        w_nxt_state = S_ON;
      end else begin
        w_nxt_state = S_OFF;
      end

      if (w_nxt_state == S_ON) begin
        w_onehot  = 4'b0001 << w_nxt_dig;
        w_nxt_an  = ANODE_ACTIVE_LOW ? ~w_onehot : w_onehot;
        w_nxt_seg = r_snap[w_nxt_dig];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dig        <= '0;
      r_snap       <= '1;
      r_bright     <= 3'd7;
      r_an         <= AN_OFF;
      r_seg        <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_dig        <= w_nxt_dig;
      r_an         <= w_nxt_an;
      r_seg        <= w_nxt_seg;
      r_frame_tick <= w_frame_start;
      if (w_frame_start) begin
        r_snap   <= {i_seg_in_4, i_seg_in_3, i_seg_in_2, i_seg_in_1};
        r_bright <= i_bright;
      end
    end
  end

  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DIGIT_TICKS=16, BLANK_TICKS=2.
module tb_seg_scan_mux;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] seg_in_1, seg_in_2, seg_in_3, seg_in_4;
  logic [2:0] bright;
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_pat [4];

  seg_scan_mux #(
    .DIGIT_TICKS     (16),
    .BLANK_TICKS     (2),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_seg_in_1  (seg_in_1),
    .i_seg_in_2  (seg_in_2),
    .i_seg_in_3  (seg_in_3),
    .i_seg_in_4  (seg_in_4),
    .i_bright    (bright),
    .o_an        (an),
    .o_seg       (seg),
    .o_frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check_eq({tag, " an"}, 32'(an), 32'h0000000F);
    check_eq({tag, " seg"}, 32'(seg), 32'h000000FF);
    check_eq({tag, " ft"}, 32'(frame_tick), 32'h0);
  endtask

  // Walks a frame from its cycle 0, checking every cycle. At digit 1 offset 3 the
  // inputs bright/seg_in_3 are driven with nb/ns3. Stops (without advancing)
  // after checking (stop_d, stop_off); otherwise ends at the next frame's cycle 0.
  task automatic scan(input int lit, input logic [2:0] nb, input logic [7:0] ns3,
                      input int stop_d, input int stop_off);
    bit         stop;
    bit         on;
    logic [3:0] one;
    logic [3:0] ea;
    logic [7:0] es;
    stop = 1'b0;
    for (int d = 0; d < 4 && !stop; d++) begin
      for (int off = 0; off < 16 && !stop; off++) begin
        on  = (off >= 2) && (off < 2 + lit);
        one = 4'b0001 << d;
        ea  = on ? ~one : 4'hF;
        es  = on ? exp_pat[d] : 8'hFF;
        check_eq($sformatf("an d%0d o%0d", d, off), 32'(an), 32'(ea));
        check_eq($sformatf("seg d%0d o%0d", d, off), 32'(seg), 32'(es));
        check_eq($sformatf("ft d%0d o%0d", d, off), 32'(frame_tick), 32'((d == 0) && (off == 0)));
        if (d == stop_d && off == stop_off) begin
          stop = 1'b1;
        end else begin
          if (d == 1 && off == 3) begin
            bright   = nb;
            seg_in_3 = ns3;
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    seg_in_1 = 8'hC0;
    seg_in_2 = 8'hF9;
    seg_in_3 = 8'hA4;
    seg_in_4 = 8'hB0;
    bright   = 3'd7;
    exp_pat[0] = 8'hC0;
    exp_pat[1] = 8'hF9;
    exp_pat[2] = 8'hA4;
    exp_pat[3] = 8'hB0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_blank($sformatf("reset%0d", i));
    end
    rst = 1'b0;
    @(negedge clk);

    // Full scans at full brightness; second frame requests bright=3 and seg_in_3=80
    scan(14, 3'd7, 8'hA4, -1, -1);
    scan(14, 3'd3, 8'h80, -1, -1);

    // Dimming frames; new pattern on digit 3 appears only from this frame
    exp_pat[2] = 8'h80;
    scan(7, 3'd0, 8'h80, -1, -1);
    scan(1, 3'd7, 8'hA4, -1, -1);

    // Enable drop at digit 2 offset 5
    exp_pat[2] = 8'hA4;
    scan(14, 3'd7, 8'hA4, 1, 5);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_blank($sformatf("en_off%0d", i));
    end
    en = 1'b1;
    @(negedge clk);
    scan(14, 3'd7, 8'hA4, -1, -1);

    // Reset pulse in digit 4 ON phase
    scan(14, 3'd7, 8'hA4, 3, 4);
    rst = 1'b1;
    @(negedge clk);
    check_blank("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    scan(14, 3'd7, 8'hA4, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
